split_slave_ctrl: RTL and testbench
===================================

# split_slave_ctrl

Slave-side transfer controller placed between the system bus and one slow memory-backed slave (slots 0–2 behind the address decoder). It turns non-locked transfers into split transactions: the requesting master gets a SPLIT response and the access runs in the background. When the access completes, the controller drives `sb_split_ar` so the arbiter re-grants that master, and the result is handed back on its return. Locked transfers (`sb_mastlock`=1) are never split; they are served directly with wait states.

## Interface
- `ADDR_W`, 14, bus address width
- `DATA_W`, 32, bus data width
- `TIMEOUT`, 16, cycles to wait for a released master before re-pulsing `sb_split_ar`; legal range ≥2
- `clk`  in  1  bus clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `sel`  in  1  decoder select for this slave
- `sb_masters`  in  2  current bus owner: 00 none, 01 M1, 10 M2
- `sb_mastlock`  in  1  owner holds a locked sequence
- `haddr`  in  ADDR_W  transfer address
- `hwrite`  in  1  1 = write, 0 = read
- `wdata`  in  DATA_W  write data, valid with `sel`
- `hready`  out  1  1 = transfer phase complete
- `resp`  out  2  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT
- `rdata`  out  DATA_W  read data, valid with OKAY on a read
- `sb_split_ar`  out  2  one-cycle release pulse to the arbiter: 01 M1, 10 M2
- `mem_req`  out  1  backend access request, held high until ack
- `mem_we`, `mem_addr`, `mem_wdata`  out  1/ADDR_W/DATA_W  backend command, stable while `mem_req`=1
- `mem_rdata`  in  DATA_W  backend read data, valid with `mem_ack`
- `mem_ack`  in  1  single-cycle completion pulse

## Operation
- All outputs are registered.
- Reset values:
  - `hready`=1, `resp`=00, `rdata`=0, `sb_split_ar`=00, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - State IDLE, split slot empty, timeout counter 0.
- A transfer is "seen" on an edge where `sel`=1 and `sb_masters`≠00. `sb_masters`=11 is treated as no transfer.
- States: IDLE, LOCK_XFER, BG_ACCESS, RELEASE, WAIT_RETURN, DONE.
- IDLE:
  - On a locked transfer: latch the command, assert `mem_req`, drop `hready`, go to LOCK_XFER.
  - On an unlocked transfer: latch the command and the master ID, drive `resp`=11 with `hready`=1 for one cycle, assert `mem_req`, go to BG_ACCESS.
- LOCK_XFER:
  - On `mem_ack`: drop `mem_req`, capture `mem_rdata` into `rdata` (reads only), drive `hready`=1 and `resp`=00 for one cycle.
  - Then return to the state saved on entry: IDLE, or WAIT_RETURN if a split slot is pending.
- BG_ACCESS:
  - On `mem_ack`: drop `mem_req`, store the read data in the slot buffer, go to RELEASE.
  - Any transfer seen here: locked → `hready`=0 (wait) until the memory is free, then served as in LOCK_XFER; unlocked → one-cycle RETRY (`resp`=10, `hready`=1).
- RELEASE: `sb_split_ar` = one-hot of the stored master for exactly one cycle. Clear the counter. Go to WAIT_RETURN.
- WAIT_RETURN:
  - Stored master returns (`sb_masters`=stored ID, `sel`=1): go to DONE.
  - Other master, unlocked: RETRY.
  - Other master, locked: served via LOCK_XFER; the slot is preserved.
  - The counter increments each cycle. When it reaches `TIMEOUT`-1, go back to RELEASE (re-pulse).
- DONE: `resp`=00, `hready`=1, `rdata`=slot buffer (0 for writes), for one cycle. The slot is freed. Go to IDLE.
- Only one split slot exists; ERROR is never generated by this block.
- `rst` asserted in any state: immediate return to reset values next edge. The pending slot and any in-flight `mem_req` are abandoned; a later stray `mem_ack` is ignored in IDLE.

## Timing
- Transfer seen at edge N → SPLIT/RETRY/wait response visible after edge N, held one cycle.
- Split read latency to release: `mem_ack` at edge M → `sb_split_ar` high during cycle M+1 → OKAY+data one cycle after the master is seen again.
- Locked transfer: `hready`=0 from N+1 until the cycle after `mem_ack`. Minimum 2 cycles with 0-latency ack.
- `mem_req` rises the cycle after acceptance and falls the cycle after `mem_ack`. `mem_ack` while `mem_req`=0 is ignored.
- Simultaneous `mem_ack` and an incoming transfer in BG_ACCESS: the transfer receives RETRY; the ack is still honoured.

## Test plan
- Unlocked read by M1 at addr 0x0010, backend ack 3 cycles later with 0xDEADBEEF → `resp`=11 one cycle; `sb_split_ar`=01 one cycle after ack; M1 returns → `resp`=00, `rdata`=0xDEADBEEF, `hready`=1.
- M1 split pending in BG_ACCESS, M2 unlocked write → M2 gets `resp`=10 for one cycle; `mem_addr` unchanged.
- Locked M2 write of 0x12345678 at 0x0200 while in WAIT_RETURN for M1 → `hready`=0 until ack, then OKAY; M1 slot data still returned intact afterwards.
- M1 released but never returns, `TIMEOUT`=16 → `sb_split_ar`=01 pulses 16 cycles apart, each exactly one cycle.
- `rst` pulsed during BG_ACCESS → all outputs at reset values next cycle; a late `mem_ack` produces no `sb_split_ar`.
- `sb_masters`=11 with `sel`=1 → no response change, `mem_req` stays 0.

Source files
------------

// File: rtl/split_slave_ctrl.sv
// rtl/split_slave_ctrl.sv - split-transaction controller for one slow memory-backed bus slave
// Unlocked transfers are split and run in the background; locked transfers are served in place.
module split_slave_ctrl #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic [1:0]        sb_masters,
  input  logic              sb_mastlock,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hwrite,
  input  logic [DATA_W-1:0] wdata,
  output logic              hready,
  output logic [1:0]        resp,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        sb_split_ar,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_RETRY = 2'b10;
  localparam logic [1:0] RESP_SPLIT = 2'b11;
  localparam int         CW         = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, LOCK_XFER, BG_ACCESS, RELEASE, WAIT_RETURN, DONE
  } state_t;

  state_t            state;
  state_t            ret_state;
  logic [1:0]        slot_master;
  logic              slot_we;
  logic [DATA_W-1:0] slot_data;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_next;
  logic              lock_pend;
  logic              lk_we;
  logic [ADDR_W-1:0] lk_addr;
  logic [DATA_W-1:0] lk_wdata;
  logic              xfer;

  assign xfer     = sel && (sb_masters == 2'b01 || sb_masters == 2'b10);
  assign cnt_next = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ret_state   <= IDLE;
      hready      <= 1'b1;
      resp        <= RESP_OKAY;
      rdata       <= '0;
      sb_split_ar <= 2'b00;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      slot_master <= 2'b00;
      slot_we     <= 1'b0;
      slot_data   <= '0;
      cnt         <= '0;
      lock_pend   <= 1'b0;
      lk_we       <= 1'b0;
      lk_addr     <= '0;
      lk_wdata    <= '0;
    end else begin
      // Response and release outputs are single-cycle unless a state holds them.
      hready      <= 1'b1;
      resp        <= RESP_OKAY;
      sb_split_ar <= 2'b00;
      case (state)
        IDLE: begin
          if (xfer) begin
            mem_we    <= hwrite;
            mem_addr  <= haddr;
            mem_wdata <= wdata;
            mem_req   <= 1'b1;
            if (sb_mastlock) begin
              hready    <= 1'b0;
              ret_state <= IDLE;
              state     <= LOCK_XFER;
            end else begin
              resp        <= RESP_SPLIT;
              slot_master <= sb_masters;
              slot_we     <= hwrite;
              state       <= BG_ACCESS;
            end
          end
        end
        LOCK_XFER: begin
          if (!mem_req) begin
            // Locked command deferred from BG_ACCESS: issue it now the backend is free.
            mem_we    <= lk_we;
            mem_addr  <= lk_addr;
            mem_wdata <= lk_wdata;
            mem_req   <= 1'b1;
            hready    <= 1'b0;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) rdata <= mem_rdata;
            state <= ret_state;
            if (ret_state == RELEASE) sb_split_ar <= slot_master;
          end else begin
            hready <= 1'b0;
          end
        end
        BG_ACCESS: begin
          if (xfer && !lock_pend) begin
            if (sb_mastlock) begin
              lk_we     <= hwrite;
              lk_addr   <= haddr;
              lk_wdata  <= wdata;
              lock_pend <= 1'b1;
              hready    <= 1'b0;
            end else begin
              resp <= RESP_RETRY;
            end
          end
          if (lock_pend) hready <= 1'b0;
          if (mem_ack && mem_req) begin
            mem_req   <= 1'b0;
            slot_data <= mem_rdata;
            if (lock_pend || (xfer && sb_mastlock)) begin
              lock_pend <= 1'b0;
              hready    <= 1'b0;
              ret_state <= RELEASE;
              state     <= LOCK_XFER;
            end else begin
              sb_split_ar <= slot_master;
              state       <= RELEASE;
            end
          end
        end
        RELEASE: begin
          cnt   <= '0;
          state <= WAIT_RETURN;
        end
        WAIT_RETURN: begin
          if (xfer && sb_masters == slot_master) begin
            rdata <= slot_we ? '0 : slot_data;
            state <= DONE;
          end else if (xfer && sb_mastlock) begin
            mem_we    <= hwrite;
            mem_addr  <= haddr;
            mem_wdata <= wdata;
            mem_req   <= 1'b1;
            hready    <= 1'b0;
            ret_state <= WAIT_RETURN;
            state     <= LOCK_XFER;
          end else begin
            if (xfer) resp <= RESP_RETRY;
            if (cnt_next == CW'(TIMEOUT - 1)) begin
              sb_split_ar <= slot_master;
              state       <= RELEASE;
            end else begin
              cnt <= cnt_next;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_split_slave_ctrl.sv
// tb/tb_split_slave_ctrl.sv - self-checking bench for split_slave_ctrl
module tb_split_slave_ctrl;
  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              sel;
  logic [1:0]        sb_masters;
  logic              sb_mastlock;
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic [DATA_W-1:0] wdata;
  logic              hready;
  logic [1:0]        resp;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        sb_split_ar;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  split_slave_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .sel(sel), .sb_masters(sb_masters), .sb_mastlock(sb_mastlock),
    .haddr(haddr), .hwrite(hwrite), .wdata(wdata), .hready(hready), .resp(resp),
    .rdata(rdata), .sb_split_ar(sb_split_ar), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        hready;
    logic [1:0]  resp;
    logic        chk_rdata;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    string       name;
    logic        sel;
    logic [1:0]  m;
    logic        lock;
    logic [13:0] addr;
    logic        we;
    logic        exp_hready;
    logic [1:0]  exp_resp;
    logic        exp_req;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[7];
  int   cmps = 0;
  int   errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input string name, input logic h, input logic [1:0] r,
                             input logic c, input logic [31:0] d);
    exp_t e;
    e.name = name; e.hready = h; e.resp = r; e.chk_rdata = c; e.rdata = d;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      cmps++; errs++;
      $display("FAIL scoreboard: queue empty when response sampled");
      return;
    end
    e = sb_q.pop_front();
    chk($sformatf("%s.hready", e.name), 32'(hready), 32'(e.hready));
    chk($sformatf("%s.resp", e.name), 32'(resp), 32'(e.resp));
    if (e.chk_rdata) chk($sformatf("%s.rdata", e.name), rdata, e.rdata);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    sel = 0; sb_masters = 2'b00; sb_mastlock = 0; haddr = '0; hwrite = 0; wdata = '0;
  endtask

  task automatic drive(input logic s, input logic [1:0] m, input logic l,
                       input logic [13:0] a, input logic w, input logic [31:0] d);
    sel = s; sb_masters = m; sb_mastlock = l; haddr = a; hwrite = w; wdata = d;
  endtask

  task automatic do_reset();
    rst = 1; idle_bus(); mem_ack = 0; mem_rdata = '0;
    step();
    rst = 0;
  endtask

  task automatic ack(input logic [31:0] d);
    mem_ack = 1; mem_rdata = d;
    step();
    mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic split_start(input string name, input logic [1:0] m, input logic [13:0] a);
    drive(1, m, 0, a, 0, 0);
    expect_resp(name, 1, 2'b11, 0, 0);
    step();
    idle_bus();
    pop_check();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".hready"}, 32'(hready), 1);
    chk({tag, ".resp"}, 32'(resp), 0);
    chk({tag, ".rdata"}, rdata, 0);
    chk({tag, ".ar"}, 32'(sb_split_ar), 0);
    chk({tag, ".mem_req"}, 32'(mem_req), 0);
    chk({tag, ".mem_we"}, 32'(mem_we), 0);
    chk({tag, ".mem_addr"}, 32'(mem_addr), 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last, pulses;
    logic prev_nz;

    vecs[0] = '{"no_sel",      0, 2'b01, 0, 14'h0010, 0, 1, 2'b00, 0};
    vecs[1] = '{"no_master",   1, 2'b00, 0, 14'h0010, 0, 1, 2'b00, 0};
    vecs[2] = '{"master11",    1, 2'b11, 0, 14'h0010, 0, 1, 2'b00, 0};
    vecs[3] = '{"master11_lk", 1, 2'b11, 1, 14'h0020, 1, 1, 2'b00, 0};
    vecs[4] = '{"split_m1_rd", 1, 2'b01, 0, 14'h0123, 0, 1, 2'b11, 1};
    vecs[5] = '{"split_m2_wr", 1, 2'b10, 0, 14'h0456, 1, 1, 2'b11, 1};
    vecs[6] = '{"lock_m1_rd",  1, 2'b01, 1, 14'h0789, 0, 0, 2'b00, 1};

    do_reset();
    check_reset_outputs("reset0");

    foreach (vecs[i]) begin
      do_reset();
      drive(vecs[i].sel, vecs[i].m, vecs[i].lock, vecs[i].addr, vecs[i].we, 32'h0BAD_0000 + i);
      expect_resp(vecs[i].name, vecs[i].exp_hready, vecs[i].exp_resp, 0, 0);
      step();
      idle_bus();
      pop_check();
      chk({vecs[i].name, ".mem_req"}, 32'(mem_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req) begin
        chk({vecs[i].name, ".mem_addr"}, 32'(mem_addr), 32'(vecs[i].addr));
        chk({vecs[i].name, ".mem_we"}, 32'(mem_we), 32'(vecs[i].we));
      end
      step();
      chk({vecs[i].name, ".resp_next"}, 32'(resp), 0);
    end

    // Reset out of a locked wait with a live mem_req.
    do_reset();
    check_reset_outputs("reset1");

    // Split read by M1, backend ack three cycles later.
    split_start("b_split", 2'b01, 14'h0010);
    chk("b.mem_req", 32'(mem_req), 1);
    chk("b.mem_addr", 32'(mem_addr), 32'h0010);
    chk("b.mem_we", 32'(mem_we), 0);
    step();
    chk("b.resp_one_cycle", 32'(resp), 0);
    step();
    ack(32'hDEADBEEF);
    chk("b.ar_pulse", 32'(sb_split_ar), 32'h1);
    chk("b.mem_req_drop", 32'(mem_req), 0);
    step();
    chk("b.ar_one_cycle", 32'(sb_split_ar), 0);
    chk("b.rdata_not_early", rdata, 0);
    drive(1, 2'b01, 0, 14'h0010, 0, 0);
    expect_resp("b_done", 1, 2'b00, 1, 32'hDEADBEEF);
    step();
    idle_bus();
    pop_check();
    step();

    // M2 retried during BG_ACCESS, then locked M2 write while M1 waits to return.
    split_start("c_split", 2'b01, 14'h0020);
    drive(1, 2'b10, 0, 14'h0300, 1, 32'h5555AAAA);
    expect_resp("c_retry", 1, 2'b10, 0, 0);
    step();
    idle_bus();
    pop_check();
    chk("c.mem_addr_kept", 32'(mem_addr), 32'h0020);
    chk("c.mem_we_kept", 32'(mem_we), 0);
    step();
    chk("c.retry_one_cycle", 32'(resp), 0);
    ack(32'hA5A50001);
    chk("c.ar_pulse", 32'(sb_split_ar), 32'h1);
    step();
    drive(1, 2'b10, 1, 14'h0200, 1, 32'h12345678);
    step();
    idle_bus();
    chk("d.hready_wait", 32'(hready), 0);
    chk("d.mem_req", 32'(mem_req), 1);
    chk("d.mem_addr", 32'(mem_addr), 32'h0200);
    chk("d.mem_we", 32'(mem_we), 1);
    chk("d.mem_wdata", mem_wdata, 32'h12345678);
    step();
    chk("d.hready_hold", 32'(hready), 0);
    expect_resp("d_lock_done", 1, 2'b00, 0, 0);
    ack(32'h0);
    pop_check();
    chk("d.mem_req_drop", 32'(mem_req), 0);
    step();
    drive(1, 2'b01, 0, 14'h0020, 0, 0);
    expect_resp("d_m1_return", 1, 2'b00, 1, 32'hA5A50001);
    step();
    idle_bus();
    pop_check();
    step();

    // Reset during BG_ACCESS; a late ack must not release anyone.
    split_start("f_split", 2'b01, 14'h0040);
    step();
    rst = 1;
    step();
    rst = 0;
    check_reset_outputs("f_reset");
    mem_ack = 1; mem_rdata = 32'h77777777;
    step();
    mem_ack = 0; mem_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("f.ar_quiet%0d", i), 32'(sb_split_ar), 0);
      chk($sformatf("f.req_quiet%0d", i), 32'(mem_req), 0);
      step();
    end

    // Locked read from IDLE with an immediate ack.
    drive(1, 2'b01, 1, 14'h0040, 0, 0);
    step();
    idle_bus();
    chk("g.hready_wait", 32'(hready), 0);
    chk("g.mem_req", 32'(mem_req), 1);
    expect_resp("g_lock_rd", 1, 2'b00, 1, 32'hCAFE0042);
    ack(32'hCAFE0042);
    pop_check();
    step();
    chk("g.hready_after", 32'(hready), 1);
    chk("g.mem_req_after", 32'(mem_req), 0);

    // Locked transfer arriving during BG_ACCESS is deferred until the backend frees up.
    split_start("h_split", 2'b01, 14'h0050);
    drive(1, 2'b10, 1, 14'h0060, 1, 32'h00000077);
    step();
    idle_bus();
    chk("h.hready_wait", 32'(hready), 0);
    chk("h.mem_addr_kept", 32'(mem_addr), 32'h0050);
    ack(32'h00000099);
    chk("h.hready_still", 32'(hready), 0);
    chk("h.mem_req_gap", 32'(mem_req), 0);
    step();
    chk("h.lock_req", 32'(mem_req), 1);
    chk("h.lock_addr", 32'(mem_addr), 32'h0060);
    chk("h.lock_we", 32'(mem_we), 1);
    chk("h.hready_wait2", 32'(hready), 0);
    expect_resp("h_lock_done", 1, 2'b00, 0, 0);
    ack(32'h0);
    pop_check();
    chk("h.ar_pulse", 32'(sb_split_ar), 32'h1);
    step();
    drive(1, 2'b01, 0, 14'h0050, 0, 0);
    expect_resp("h_m1_return", 1, 2'b00, 1, 32'h00000099);
    step();
    idle_bus();
    pop_check();
    step();

    // Released master never returns: re-pulse every TIMEOUT cycles.
    split_start("e_split", 2'b01, 14'h0030);
    step();
    ack(32'h00000011);
    last = -1; pulses = 0; prev_nz = 0;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) step();
      if (sb_split_ar != 2'b00) begin
        chk($sformatf("e.ar_val%0d", i), 32'(sb_split_ar), 32'h1);
        chk($sformatf("e.ar_single%0d", i), 32'(prev_nz), 0);
        if (last >= 0) chk($sformatf("e.spacing%0d", i), 32'(i - last), TIMEOUT);
        last = i;
        pulses++;
      end
      prev_nz = (sb_split_ar != 2'b00);
    end
    chk("e.pulse_count", 32'(pulses), 4);
    chk("e.first_pulse_at_ack", 32'(last - 3 * TIMEOUT), 0);
    do_reset();

    chk("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
